if_stage: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the ID-stage decoder.
- Owns the PC register and drives the synchronous instruction SRAM.
- Selects the next PC from sequential, branch/jump redirect, flush and stall sources.
- Presents a registered {id_valid, id_pc, id_inst} to ID, and holds fetched instructions across stalls so the SRAM can idle.

---
 rtl/if_stage.sv | 66 ++++++
 tb/tb_if_stage.sv | 116 +++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction fetch with PC select, sync SRAM drive and stall hold buffer.
// Define IF_ADEL_EN to flag misaligned fetch addresses on id_adel instead of fetching them.
module if_stage #(
  parameter int PC_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_e,
  input  logic [PC_W-1:0] br_addr,
  input  logic            flush,
  input  logic [PC_W-1:0] flush_pc,
  output logic            inst_sram_en,
  output logic [PC_W-1:0] inst_sram_addr,
  input  logic [31:0]     inst_sram_rdata,
`ifdef IF_ADEL_EN
  output logic            id_adel,
`endif
  output logic            id_valid,
  output logic [PC_W-1:0] id_pc,
  output logic [31:0]     id_inst
);
  logic [PC_W-1:0] pc_reg, next_pc;
  logic            ce, buf_vld, fetch;
  logic [31:0]     inst_buf;
  assign fetch = rst && (flush || !stall);
  always_comb next_pc = !rst ? RESET_PC : flush ? flush_pc : stall ? pc_reg : br_e ? br_addr : pc_reg + PC_W'(4);
  assign inst_sram_addr = next_pc;
`ifdef IF_ADEL_EN
  logic mis;
  assign mis = next_pc[1:0] != 2'b00;
  assign inst_sram_en = fetch && !mis;
`else
  assign inst_sram_en = fetch;
`endif
  // The first stalled edge captures the word still on the SRAM bus so the SRAM may idle afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_reg <= RESET_PC - PC_W'(4);
      ce <= 1'b0;
      buf_vld <= 1'b0;
      inst_buf <= '0;
`ifdef IF_ADEL_EN
      id_adel <= 1'b0;
`endif
    end else if (fetch) begin
      pc_reg <= next_pc;
      ce <= 1'b1;
      buf_vld <= 1'b0;
`ifdef IF_ADEL_EN
      id_adel <= mis;
`endif
    end else if (ce && !buf_vld) begin
      inst_buf <= inst_sram_rdata;
      buf_vld <= 1'b1;
    end
  end
  assign id_pc = pc_reg;
  assign id_valid = ce;
`ifdef IF_ADEL_EN
  assign id_inst = (!ce || id_adel) ? 32'h0 : buf_vld ? inst_buf : inst_sram_rdata;
`else
  assign id_inst = !ce ? 32'h0 : buf_vld ? inst_buf : inst_sram_rdata;
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized scoreboard bench for if_stage with a behavioural fetch model.
module tb_if_stage;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  logic clk = 0, rst = 0, stall = 0, br_e = 0, flush = 0;
  logic [31:0] br_addr = 0, flush_pc = 0, rdata = 0;
  logic en, id_valid;
  logic [31:0] addr, id_pc, id_inst;
`ifdef IF_ADEL_EN
  logic id_adel;
`endif
  typedef struct packed {logic [31:0] pc; logic [31:0] inst; logic adel;} item_t;
  item_t q[$];
  int errors = 0, checks = 0;
  logic [31:0] model_pc = 0;
  bit rst_done = 0;
  always #5 clk = ~clk;
  if_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .br_e(br_e), .br_addr(br_addr),
    .flush(flush), .flush_pc(flush_pc), .inst_sram_en(en), .inst_sram_addr(addr),
    .inst_sram_rdata(rdata),
`ifdef IF_ADEL_EN
    .id_adel(id_adel),
`endif
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst)
  );
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction
  // SRAM returns junk whenever it is not enabled, so only the hold buffer can keep a word alive.
  always @(posedge clk) rdata <= en ? mem(addr) : $urandom();
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] ba,
                      input logic f, input logic [31:0] fp);
    logic [31:0] ea;
    logic go, ad;
    rst = r; stall = s; br_e = b; br_addr = ba; flush = f; flush_pc = fp;
    go = r && (f || !s);
    ea = !r ? RST_PC : f ? fp : s ? model_pc : b ? ba : model_pc + 32'd4;
    ad = 1'b0;
`ifdef IF_ADEL_EN
    ad = go && ea[1:0] != 2'b00;
`endif
    @(negedge clk);
    check("sram_en", 32'(en), 32'(go && !ad));
    check("sram_addr", addr, ea);
    @(posedge clk);
    if (!r) begin
      model_pc = RST_PC - 32'd4;
      q.delete();
      rst_done = 1;
    end else begin
      rst_done = 0;
      if (go) begin
        model_pc = ea;
        q.push_back('{ea, (ad ? 32'h0 : mem(ea)), ad});
      end
    end
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst && rst_done) begin
      check("rst_valid", 32'(id_valid), 32'd0);
      check("rst_pc", id_pc, RST_PC - 32'd4);
      check("rst_inst", id_inst, 32'd0);
    end else if (rst) begin
      while (q.size() > 1) void'(q.pop_front());
      check("id_valid", 32'(id_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        check("id_pc", id_pc, q[0].pc);
        check("id_inst", id_inst, q[0].inst);
`ifdef IF_ADEL_EN
        check("id_adel", 32'(id_adel), 32'(q[0].adel));
`endif
      end
    end
  end
  initial begin
    logic r, s, b, f;
    logic [31:0] ba, fp;
    #1;
    repeat (3) step(0, 0, 0, 0, 0, 0);
    repeat (5) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 32'hBFC0_0100, 0, 0);
    repeat (2) step(1, 0, 0, 0, 0, 0);
    repeat (3) step(1, 1, 0, 0, 0, 0);
    repeat (2) step(1, 0, 0, 0, 0, 0);
    repeat (2) step(1, 1, 1, 32'hBFC0_0200, 0, 0);
    step(1, 1, 1, 32'hBFC0_0200, 1, 32'hBFC0_0380);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 32'hFFFF_FFF8);
    repeat (3) step(1, 0, 0, 0, 0, 0);
`ifdef IF_ADEL_EN
    step(1, 0, 1, 32'hBFC0_0102, 0, 0);
    step(1, 0, 0, 0, 1, 32'hBFC0_0000);
`endif
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 49) != 0;
      s = $urandom_range(0, 9) < 3;
      b = $urandom_range(0, 9) < 2;
      f = $urandom_range(0, 9) == 0;
      ba = $urandom();
      fp = $urandom();
      if ($urandom_range(0, 9) != 0) ba[1:0] = 2'b00;
      if ($urandom_range(0, 9) != 0) fp[1:0] = 2'b00;
      step(r, s, b, ba, f, fp);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
